// File: rtl/fab_gpio_apb.sv
// Fabric GPIO controller with APB3 slave: per-channel input synchroniser, output/OE
// registers, level/edge interrupt with sticky W1C status, and one registered INT line.
module fab_gpio_apb #(
    parameter int GPIO_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  FIC_0_CLK,
    input  logic                  FAB_RESET,
    input  logic [7:0]            PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [GPIO_WIDTH-1:0] GPIO_IN,
    output logic [GPIO_WIDTH-1:0] GPIO_OUT,
    output logic [GPIO_WIDTH-1:0] GPIO_OE,
    output logic                  INT
);
    localparam int W = GPIO_WIDTH;

    logic [SYNC_STAGES-1:0][W-1:0] sync_reg;
    logic [W-1:0] s_d_reg;
    logic [W-1:0] data_out_reg;
    logic [W-1:0] oe_reg;
    logic [W-1:0] int_en_reg;
    logic [W-1:0] int_type_reg;
    logic [W-1:0] int_pol_reg;
    logic [W-1:0] int_both_reg;
    logic [W-1:0] int_status_reg;
    logic         int_reg;

    logic [W-1:0] s;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] evt;
    logic [W-1:0] w1c_mask;
    logic [W-1:0] status_next;
    logic [W-1:0] rd_sel;
    logic [31:0]  rd_word;
    logic [5:0]   word_sel;
    logic         mapped;
    logic         access;
    logic         wr_en;
    logic         unused_ok;

    // Byte-lane bits and any PWDATA bits above the channel count are not used.
    assign unused_ok = ^{PADDR[1:0], PWDATA};

    assign word_sel = PADDR[7:2];
    assign mapped   = (word_sel <= 6'd8);
    assign access   = PSEL & PENABLE;
    assign wr_en    = access & PWRITE & mapped;

    assign s    = sync_reg[SYNC_STAGES-1];
    assign rise = s & ~s_d_reg;
    assign fall = ~s & s_d_reg;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_evt
            logic edge_hit;
            assign edge_hit = int_both_reg[gi] ? (rise[gi] | fall[gi])
                                               : (int_pol_reg[gi] ? rise[gi] : fall[gi]);
            assign evt[gi]  = int_en_reg[gi] &
                              (int_type_reg[gi] ? edge_hit : (s[gi] == int_pol_reg[gi]));
        end
    endgenerate

    // A new event in the same cycle as a W1C keeps the bit set.
    assign w1c_mask    = (wr_en && (word_sel == 6'd7)) ? PWDATA[W-1:0] : '0;
    assign status_next = (int_status_reg & ~w1c_mask) | evt;

    always_ff @(posedge FIC_0_CLK) begin
        if (FAB_RESET) begin
            sync_reg <= '0;
            s_d_reg  <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], GPIO_IN};
            end else begin
                sync_reg <= GPIO_IN;
            end
            s_d_reg <= s;
        end
    end

    always_ff @(posedge FIC_0_CLK) begin
        if (FAB_RESET) begin
            data_out_reg   <= '0;
            oe_reg         <= '0;
            int_en_reg     <= '0;
            int_type_reg   <= '0;
            int_pol_reg    <= '0;
            int_both_reg   <= '0;
            int_status_reg <= '0;
            int_reg        <= 1'b0;
        end else begin
            if (wr_en) begin
                case (word_sel)
                    6'd1:    data_out_reg <= PWDATA[W-1:0];
                    6'd2:    oe_reg       <= PWDATA[W-1:0];
                    6'd3:    int_en_reg   <= PWDATA[W-1:0];
                    6'd4:    int_type_reg <= PWDATA[W-1:0];
                    6'd5:    int_pol_reg  <= PWDATA[W-1:0];
                    6'd6:    int_both_reg <= PWDATA[W-1:0];
                    default: ;
                endcase
            end
            int_status_reg <= status_next;
            int_reg        <= |(int_status_reg & int_en_reg);
        end
    end

    always_comb begin
        rd_sel = '0;
        case (word_sel)
            6'd0:    rd_sel = s;
            6'd1:    rd_sel = data_out_reg;
            6'd2:    rd_sel = oe_reg;
            6'd3:    rd_sel = int_en_reg;
            6'd4:    rd_sel = int_type_reg;
            6'd5:    rd_sel = int_pol_reg;
            6'd6:    rd_sel = int_both_reg;
            6'd7:    rd_sel = int_status_reg;
            6'd8:    rd_sel = int_status_reg & int_en_reg;
            default: rd_sel = '0;
        endcase
        rd_word        = '0;
        rd_word[W-1:0] = rd_sel;
    end

    assign PRDATA   = PSEL ? rd_word : 32'h0;
    assign PREADY   = 1'b1;
    assign PSLVERR  = access & ~mapped;
    assign GPIO_OUT = data_out_reg;
    assign GPIO_OE  = oe_reg;
    assign INT      = int_reg;

endmodule
